instr_fetch_stage: RTL

- Instruction-fetch stage of the pipelined processor, directly upstream of decode.
- Owns the PC and issues reads to a synchronous instruction memory with 1-cycle read latency.
- Registers {PC, PC+4, instruction, valid} into the IF/ID pipeline register consumed by decode.
- Honours stall from the hazard unit without losing the in-flight read, and applies branch/jump redirect from EX with flush.

---
 rtl/pipeline_pkg.sv | 24 ++
 rtl/instr_fetch_stage_if.sv | 15 +
 rtl/instr_fetch_stage_if_id_reg.sv | 30 +++
 rtl/instr_fetch_stage.sv | 119 +++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Types and default widths shared by the fetch stage and the decode stage that
// consumes the IF/ID register.
package pipeline_pkg;

  localparam int          ADDR_W_DEF    = 32;
  localparam int          INSTR_W_DEF   = 32;
  localparam int          CNT_W_DEF     = 16;
  localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } fetch_state_t;

  // The decode stage relies on this field order, so do not reorder it.
  typedef struct packed {
    logic [ADDR_W_DEF-1:0]  pc;
    logic [ADDR_W_DEF-1:0]  pc4;
    logic [INSTR_W_DEF-1:0] instr;
    logic                   valid;
  } ifid_t;

endpackage

// File: rtl/instr_fetch_stage_if.sv
// Instruction-memory read port: a 1-cycle-latency synchronous read.
// The fetch stage drives the master side and the memory drives the slave side.
interface instr_fetch_stage_if
  import pipeline_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF
);
  logic               Imem_Rd_o;
  logic [ADDR_W-1:0]  Imem_Addr_o;
  logic [INSTR_W-1:0] Imem_Data_i;

  modport master (output Imem_Rd_o, output Imem_Addr_o, input Imem_Data_i);
  modport slave  (input Imem_Rd_o, input Imem_Addr_o, output Imem_Data_i);
endinterface

// File: rtl/instr_fetch_stage_if_id_reg.sv
// IF/ID pipeline register. A flush inserts a bubble and keeps the PC fields.
// A flush takes priority over a load.
module if_id_reg
  import pipeline_pkg::*;
#(
  parameter logic [INSTR_W_DEF-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic  Clk,
  input  logic  Reset,
  input  logic  load,
  input  logic  flush,
  input  ifid_t d,
  output ifid_t q
);

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      q.pc    <= '0;
      q.pc4   <= '0;
      q.instr <= NOP_INSTR;
      q.valid <= 1'b0;
    end else if (flush) begin
      q.instr <= NOP_INSTR;
      q.valid <= 1'b0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/instr_fetch_stage.sv
// Instruction fetch: owns the PC, issues reads to the instruction memory, and
// fills IF/ID. A skid register holds the in-flight read across a stall.
module instr_fetch_stage
  import pipeline_pkg::*;
#(
  parameter int                 ADDR_W    = ADDR_W_DEF,
  parameter int                 INSTR_W   = INSTR_W_DEF,
  parameter logic [ADDR_W-1:0]  RESET_PC  = RESET_PC_DEF,
  parameter logic [INSTR_W-1:0] NOP_INSTR = NOP_INSTR_DEF,
  parameter int                 CNT_W     = CNT_W_DEF
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic                      Stall_i,
  input  logic                      Redirect_i,
  input  logic [ADDR_W-1:0]         Redirect_PC_i,
  instr_fetch_stage_if.master       imem,
  output logic [ADDR_W-1:0]         IFID_PC_o,
  output logic [ADDR_W-1:0]         IFID_PC4_o,
  output logic [INSTR_W-1:0]        IFID_Instr_o,
  output logic                      IFID_Valid_o,
  output logic [CNT_W-1:0]          Fetch_Count_o
);

  fetch_state_t       state_reg, state_next;
  logic [ADDR_W-1:0]  pc_reg, pc_next;
  logic [ADDR_W-1:0]  req_pc_reg, req_pc_next;
  logic               req_valid_reg, req_valid_next;
  logic [INSTR_W-1:0] skid_instr_reg, skid_instr_next;
  logic               skid_valid_reg, skid_valid_next;
  logic [CNT_W-1:0]   count_reg, count_next;

  ifid_t ifid_d, ifid_q;
  logic  ifid_load, ifid_flush;

  assign imem.Imem_Rd_o   = Reset & ~Redirect_i & ~Stall_i;
  assign imem.Imem_Addr_o = pc_reg;

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_reg      <= RUN;
      pc_reg         <= RESET_PC;
      req_pc_reg     <= '0;
      req_valid_reg  <= 1'b0;
      skid_instr_reg <= NOP_INSTR;
      skid_valid_reg <= 1'b0;
      count_reg      <= '0;
    end else begin
      state_reg      <= state_next;
      pc_reg         <= pc_next;
      req_pc_reg     <= req_pc_next;
      req_valid_reg  <= req_valid_next;
      skid_instr_reg <= skid_instr_next;
      skid_valid_reg <= skid_valid_next;
      count_reg      <= count_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    pc_next         = pc_reg;
    req_pc_next     = req_pc_reg;
    req_valid_next  = req_valid_reg;
    skid_instr_next = skid_instr_reg;
    skid_valid_next = skid_valid_reg;
    count_next      = count_reg;
    ifid_load       = 1'b0;
    ifid_flush      = 1'b0;

    // A slot with no outstanding read becomes a bubble carrying the NOP word.
    ifid_d.pc    = req_pc_reg;
    ifid_d.pc4   = req_pc_reg + ADDR_W'(4);
    ifid_d.valid = skid_valid_reg | req_valid_reg;
    ifid_d.instr = skid_valid_reg ? skid_instr_reg : imem.Imem_Data_i;
    if (!ifid_d.valid) ifid_d.instr = NOP_INSTR;

    if (Redirect_i) begin
      pc_next         = {Redirect_PC_i[ADDR_W-1:2], 2'b00};
      req_valid_next  = 1'b0;
      skid_valid_next = 1'b0;
      ifid_flush      = 1'b1;
      state_next      = RUN;
    end else if (Stall_i) begin
      // Capture only the first stalled cycle's data. Later cycles see stale memory output.
      if (req_valid_reg && !skid_valid_reg) begin
        skid_instr_next = imem.Imem_Data_i;
        skid_valid_next = 1'b1;
      end
      req_valid_next = 1'b0;
      state_next     = HOLD;
    end else begin
      ifid_load       = 1'b1;
      req_pc_next     = pc_reg;
      req_valid_next  = 1'b1;
      pc_next         = pc_reg + ADDR_W'(4);
      skid_valid_next = 1'b0;
      state_next      = RUN;
      if (ifid_d.valid) count_next = count_reg + CNT_W'(1);
    end
  end

  if_id_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id_reg (
    .Clk   (Clk),
    .Reset (Reset),
    .load  (ifid_load),
    .flush (ifid_flush),
    .d     (ifid_d),
    .q     (ifid_q)
  );

  assign IFID_PC_o     = ifid_q.pc;
  assign IFID_PC4_o    = ifid_q.pc4;
  assign IFID_Instr_o  = ifid_q.instr;
  assign IFID_Valid_o  = ifid_q.valid;
  assign Fetch_Count_o = count_reg;

endmodule
